// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch-control logic (master) and the PC unit (slave).
// Master drives the per-cycle control inputs; slave returns PC, trap PC and return-stack status.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            call;
    logic            ret;
    logic            trap;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_out;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret, trap,
        input  pc_out, pc_next, epc_out, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret, trap,
        output pc_out, pc_next, epc_out, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with trap/stall/return/redirect priority and a circular return-address stack.
// pc_next exposes the value pc_out will take at the next rising edge.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080),
    parameter int              INC          = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_unit_if.slave     pc_bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [XLEN-1:0]  pc_inc;
    logic [PTR_W-1:0] push_ptr;
    logic             push_en;
    logic             ras_empty;
    logic             ras_full;

    assign pc_inc    = pc_q + XLEN'(INC);
    // Depth is a power of two, so the pointer wraps naturally and a push on a full stack
    // lands on the oldest entry.
    assign push_ptr  = top_q + PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (pc_bus.trap) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
        end else if (!pc_bus.stall) begin
            if (pc_bus.ret) begin
                if (ras_empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d  = ras_q[top_q];
                    top_d = top_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (pc_bus.redirect_valid) begin
                pc_d = pc_bus.redirect_target;
                if (pc_bus.call) begin
                    push_en = 1'b1;
                    top_d   = push_ptr;
                    if (ras_full) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
        assign ras_d[gi] = (push_en && (push_ptr == PTR_W'(gi))) ? pc_inc : ras_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ras_q[gi] <= '0;
            end else begin
                ras_q[gi] <= ras_d[gi];
            end
        end
    end

    assign pc_bus.pc_out    = pc_q;
    assign pc_bus.pc_next   = pc_d;
    assign pc_bus.epc_out   = epc_q;
    assign pc_bus.ras_empty = ras_empty;
    assign pc_bus.ras_full  = ras_full;
    assign pc_bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the PC and return-address stack.
module tb_pc_unit;
    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam logic [31:0] TV    = 32'h0000_0080;
    localparam int          INC   = 4;
    localparam int          DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pc_unit_if #(.XLEN(XLEN)) pc_bus ();

    pc_unit #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(INC), .RAS_DEPTH(DEPTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_bus(pc_bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural state after the next rising edge.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_err;
    logic [31:0] m_ras[$];

    task automatic model_reset();
        m_pc  = RV;
        m_epc = 32'h0;
        m_err = 1'b0;
        m_ras.delete();
    endtask

    task automatic set_in(input logic st, input logic rv, input logic [31:0] tgt,
                          input logic cl, input logic rt, input logic tr);
        pc_bus.stall           = st;
        pc_bus.redirect_valid  = rv;
        pc_bus.redirect_target = tgt;
        pc_bus.call            = cl;
        pc_bus.ret             = rt;
        pc_bus.trap            = tr;
        if (tr) begin
            m_epc = m_pc;
            m_pc  = TV;
        end else if (!st) begin
            if (rt) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    m_pc  = m_pc + INC;
                    m_err = 1'b1;
                end
            end else if (rv) begin
                if (cl) begin
                    if (m_ras.size() == DEPTH) begin
                        m_ras.delete(0);
                        m_err = 1'b1;
                    end
                    m_ras.push_back(m_pc + INC);
                end
                m_pc = tgt;
            end else begin
                m_pc = m_pc + INC;
            end
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_bus.stall = 0; pc_bus.redirect_valid = 0; pc_bus.redirect_target = '0;
        pc_bus.call = 0; pc_bus.ret = 0; pc_bus.trap = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pc_bus.stall = 0; pc_bus.redirect_valid = 1; pc_bus.redirect_target = 32'h700;
        pc_bus.call = 1; pc_bus.ret = 0; pc_bus.trap = 0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++; if (pc_bus.pc_out !== RV) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc_bus.pc_out, RV); end
        n_vec++; if (pc_bus.epc_out !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h expected 0", pc_bus.epc_out); end
        n_vec++; if (pc_bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", pc_bus.ras_empty); end
        n_vec++; if (pc_bus.ras_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", pc_bus.ras_full); end
        n_vec++; if (pc_bus.ras_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", pc_bus.ras_err); end
        $display("test_reset done");
    endtask

    task automatic test_increment();
        do_reset();
        n_vec++; if (pc_bus.pc_out !== RV) begin n_err++; $display("FAIL incr_start: got %h expected %h", pc_bus.pc_out, RV); end
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 0, 32'h0, 0, 0, 0);
            n_vec++; if (pc_bus.pc_next !== RV + 32'(4 * i)) begin n_err++; $display("FAIL incr_next[%0d]: got %h expected %h", i, pc_bus.pc_next, RV + 32'(4 * i)); end
            tick();
            n_vec++; if (pc_bus.pc_out !== RV + 32'(4 * i)) begin n_err++; $display("FAIL incr_pc[%0d]: got %h expected %h", i, pc_bus.pc_out, RV + 32'(4 * i)); end
        end
        $display("test_increment done pc=%h", pc_bus.pc_out);
    endtask

    task automatic test_call_ret();
        do_reset();
        set_in(0, 0, 32'h0, 0, 0, 0); tick();
        set_in(0, 1, 32'h200, 1, 0, 0); tick();
        n_vec++; if (pc_bus.pc_out !== 32'h200) begin n_err++; $display("FAIL call_pc: got %h expected 200", pc_bus.pc_out); end
        n_vec++; if (pc_bus.ras_empty !== 1'b0) begin n_err++; $display("FAIL call_empty: got %b expected 0", pc_bus.ras_empty); end
        set_in(0, 1, 32'h900, 1, 1, 0);
        n_vec++; if (pc_bus.pc_next !== 32'h108) begin n_err++; $display("FAIL ret_next: got %h expected 108", pc_bus.pc_next); end
        tick();
        n_vec++; if (pc_bus.pc_out !== 32'h108) begin n_err++; $display("FAIL ret_pc: got %h expected 108", pc_bus.pc_out); end
        n_vec++; if (pc_bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_empty: got %b expected 1", pc_bus.ras_empty); end
        $display("test_call_ret done pc=%h", pc_bus.pc_out);
    endtask

    task automatic test_overflow();
        logic [31:0] tgts[3];
        logic [31:0] rets[3];
        tgts = '{32'h200, 32'h300, 32'h400};
        rets = '{32'h304, 32'h204, 32'h208};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, tgts[i], 1, 0, 0); tick();
            n_vec++; if (pc_bus.ras_err !== (i == 2)) begin n_err++; $display("FAIL ovf_err[%0d]: got %b expected %b", i, pc_bus.ras_err, (i == 2)); end
        end
        n_vec++; if (pc_bus.ras_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", pc_bus.ras_full); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 32'h0, 0, 1, 0); tick();
            n_vec++; if (pc_bus.pc_out !== rets[i]) begin n_err++; $display("FAIL ovf_ret[%0d]: got %h expected %h", i, pc_bus.pc_out, rets[i]); end
        end
        n_vec++; if (pc_bus.ras_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", pc_bus.ras_err); end
        n_vec++; if (pc_bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b expected 1", pc_bus.ras_empty); end
        $display("test_overflow done pc=%h", pc_bus.pc_out);
    endtask

    task automatic test_trap_stall();
        do_reset();
        repeat (3) begin set_in(0, 0, 32'h0, 0, 0, 0); tick(); end
        set_in(1, 1, 32'h500, 0, 0, 1);
        n_vec++; if (pc_bus.pc_next !== TV) begin n_err++; $display("FAIL trap_next: got %h expected %h", pc_bus.pc_next, TV); end
        tick();
        n_vec++; if (pc_bus.pc_out !== TV) begin n_err++; $display("FAIL trap_pc: got %h expected %h", pc_bus.pc_out, TV); end
        n_vec++; if (pc_bus.epc_out !== 32'h10C) begin n_err++; $display("FAIL trap_epc: got %h expected 10c", pc_bus.epc_out); end
        n_vec++; if (pc_bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL trap_ras: got %b expected 1", pc_bus.ras_empty); end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 32'h600, 1, 0, 0);
            n_vec++; if (pc_bus.pc_next !== TV) begin n_err++; $display("FAIL stall_next[%0d]: got %h expected %h", i, pc_bus.pc_next, TV); end
            tick();
            n_vec++; if (pc_bus.pc_out !== TV) begin n_err++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_bus.pc_out, TV); end
        end
        n_vec++; if (pc_bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL stall_ras: got %b expected 1", pc_bus.ras_empty); end
        $display("test_trap_stall done pc=%h", pc_bus.pc_out);
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(0, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
        n_vec++; if (pc_bus.pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_tgt: got %h expected fffffffc", pc_bus.pc_out); end
        set_in(0, 0, 32'h0, 0, 0, 0); tick();
        n_vec++; if (pc_bus.pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h expected 0", pc_bus.pc_out); end
        n_vec++; if (pc_bus.ras_err !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %b expected 0", pc_bus.ras_err); end
        $display("test_wrap done pc=%h", pc_bus.pc_out);
    endtask

    task automatic test_random();
        logic st, rv, cl, rt, tr;
        logic [31:0] tgt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tr  = ($urandom_range(15) == 0);
            st  = ($urandom_range(7) == 0);
            rt  = ($urandom_range(3) == 0);
            rv  = ($urandom_range(2) == 0);
            cl  = $urandom_range(1) == 1;
            tgt = $urandom;
            set_in(st, rv, tgt, cl, rt, tr);
            n_vec++; if (pc_bus.pc_next !== m_pc) begin n_err++; $display("FAIL rnd_next[%0d]: got %h expected %h", i, pc_bus.pc_next, m_pc); end
            tick();
            n_vec++; if (pc_bus.pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc_bus.pc_out, m_pc); end
            n_vec++; if (pc_bus.epc_out !== m_epc) begin n_err++; $display("FAIL rnd_epc[%0d]: got %h expected %h", i, pc_bus.epc_out, m_epc); end
            n_vec++; if (pc_bus.ras_empty !== (m_ras.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b expected %b", i, pc_bus.ras_empty, (m_ras.size() == 0)); end
            n_vec++; if (pc_bus.ras_full !== (m_ras.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d]: got %b expected %b", i, pc_bus.ras_full, (m_ras.size() == DEPTH)); end
            n_vec++; if (pc_bus.ras_err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, pc_bus.ras_err, m_err); end
        end
        $display("test_random done pc=%h", pc_bus.pc_out);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(0, 1, 32'h200, 1, 0, 0); tick();
        set_in(0, 1, 32'h300, 1, 0, 0); tick();
        set_in(0, 1, 32'h400, 1, 0, 0); tick();
        set_in(0, 0, 32'h0, 0, 0, 1); tick();
        n_vec++; if (pc_bus.ras_full !== 1'b1) begin n_err++; $display("FAIL arst_prefull: got %b expected 1", pc_bus.ras_full); end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (pc_bus.pc_out !== RV) begin n_err++; $display("FAIL arst_pc: got %h expected %h", pc_bus.pc_out, RV); end
        n_vec++; if (pc_bus.epc_out !== 32'h0) begin n_err++; $display("FAIL arst_epc: got %h expected 0", pc_bus.epc_out); end
        n_vec++; if (pc_bus.ras_empty !== 1'b1) begin n_err++; $display("FAIL arst_empty: got %b expected 1", pc_bus.ras_empty); end
        n_vec++; if (pc_bus.ras_full !== 1'b0) begin n_err++; $display("FAIL arst_full: got %b expected 0", pc_bus.ras_full); end
        n_vec++; if (pc_bus.ras_err !== 1'b0) begin n_err++; $display("FAIL arst_err: got %b expected 0", pc_bus.ras_err); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_async_reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_increment();
        test_call_ret();
        test_overflow();
        test_trap_stall();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value held during reset and loaded on reset release.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0080, PC value loaded on trap.
REQ-004 Parameter INC, default 4, sequential increment in bytes; power of two, 1 to 8.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 stall  in  1  hold PC and RAS this cycle.
REQ-009 redirect_valid  in  1  take redirect_target this cycle (branch or jump).
REQ-010 redirect_target  in  XLEN  redirect destination.
REQ-011 call  in  1  qualifier on redirect_valid: push return address.
REQ-012 ret  in  1  pop RAS top into PC.
REQ-013 trap  in  1  force PC to TRAP_VECTOR.
REQ-014 pc_out  out  XLEN  current PC (registered).
REQ-015 pc_next  out  XLEN  value pc_out takes at next rising edge (combinational).
REQ-016 epc_out  out  XLEN  PC captured at last trap (registered).
REQ-017 ras_empty  out  1  RAS holds zero entries.
REQ-018 ras_full  out  1  RAS holds RAS_DEPTH entries.
REQ-019 ras_err  out  1  sticky: pop on empty RAS, or push on full RAS.

Function
REQ-020 Per-cycle priority SHALL be: trap > stall > ret > redirect_valid > increment.
REQ-021 Trap: pc_out <= TRAP_VECTOR; epc_out <= current pc_out; RAS unchanged; trap overrides stall.
REQ-022 Stall without trap: pc_out, epc_out and RAS SHALL hold; call, ret and redirect_valid SHALL be ignored.
REQ-023 Ret, RAS non-empty: pc_out <= RAS top; entry count decrements by 1.
REQ-024 Ret, RAS empty: pc_out <= pc_out + INC; RAS unchanged; ras_err set.
REQ-025 ret and redirect_valid together: ret wins; redirect and call ignored.
REQ-026 Redirect: pc_out <= redirect_target; target used unmodified, no alignment masking.
REQ-027 Redirect with call: push (pc_out + INC) mod 2^XLEN.
REQ-028 Push on full RAS: oldest entry overwritten (circular); count stays RAS_DEPTH; ras_err set.
REQ-029 call without redirect_valid: ignored.
REQ-030 Increment: pc_out <= (pc_out + INC) mod 2^XLEN; 2^XLEN - INC wraps to 0 with no flag.
REQ-031 pc_next SHALL equal the value REQ-020 to REQ-030 select, including TRAP_VECTOR on trap and pc_out on stall.
REQ-032 Latency: an input sampled at edge N SHALL be reflected on pc_out after edge N.
REQ-033 RAS SHALL be LIFO: top is the most recent surviving push; ras_empty and ras_full track the count combinationally from registered state.

Reset
REQ-034 While rst_n=0, asynchronously: pc_out=RESET_VECTOR, epc_out=0, RAS count=0, ras_empty=1, ras_full=0, ras_err=0.
REQ-035 First rising edge after rst_n rises SHALL apply normal REQ-020 priority from pc_out=RESET_VECTOR.
REQ-036 Reset asserted mid-operation (during stall, trap or full RAS) SHALL return all state to REQ-034 values with no clock edge.
REQ-037 ras_err SHALL clear only on reset.

Verification
Benches use XLEN=32, RESET_VECTOR=0x100, TRAP_VECTOR=0x80, INC=4, RAS_DEPTH=2.
REQ-038 Release reset, idle 3 cycles -> pc_out 0x100, 0x104, 0x108, 0x10C; pc_next always one step ahead.
REQ-039 At pc 0x104, redirect 0x200 with call -> pc 0x200, RAS top 0x108; next cycle ret -> pc 0x108, ras_empty=1.
REQ-040 Three calls from 0x100 (targets 0x200, 0x300, 0x400) -> third sets ras_err, ras_full=1; two rets -> 0x304, then 0x204; third ret -> 0x208 via increment, ras_err stays 1.
REQ-041 At pc 0x10C, assert stall+trap+redirect(0x500) together -> pc 0x80, epc_out 0x10C, RAS unchanged; then stall alone 2 cycles -> pc holds 0x80.
REQ-042 Redirect to 0xFFFF_FFFC, then idle -> pc 0x0000_0000, no flag.
REQ-043 rst_n pulled low mid-cycle with RAS full -> pc_out 0x100, ras_empty=1, ras_err=0 before next edge.
